cover_toggle_collector: RTL and testbench
=========================================

# cover_toggle_collector

Synthesizable toggle-coverage collector, the successor to the simulation-only DPI toggle reporter. It keeps one saturating hit counter per monitored bit of a WIDTH-wide `valid` vector. On request, it drains a snapshot over a valid/ready stream of (global cover index, count) beats for FPGA/emulation readout. Each counter is cleared as it is read. Hits that land during a drain are never lost.

## Interface
- WIDTH, 62: number of monitored points; WIDTH >= 2.
- COVER_INDEX, 0: global index of point 0; point i reports index COVER_INDEX+i.
- CNT_W, 8: counter width; counters saturate at 2^CNT_W-1.
- SKIP_ZERO, 0: when 1, points with count 0 produce no beat.
- clock  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- valid  input  WIDTH  per-point hit strobe, sampled every cycle.
- enable  input  1  counting enable; when 0, hits are ignored.
- snap_req  input  1  start-snapshot pulse; ignored unless snap_busy=0.
- snap_busy  output  1  high while a snapshot is in progress.
- snap_done  output  1  one-cycle pulse when a snapshot completes.
- out_valid  output  1  beat valid.
- out_ready  input  1  consumer accepts the beat.
- out_index  output  32  COVER_INDEX+ptr, computed modulo 2^32.
- out_count  output  CNT_W  captured count.

## Operation
- Counting: counter i increments when enable && valid[i]. Saturated counters hold their value.
- FSM states:
  - IDLE: snap_req=1 -> SCAN with ptr=0.
  - SCAN: if !SKIP_ZERO or cnt[ptr]!=0, then load out_index/out_count, set out_valid=1, capture-and-clear cnt[ptr], and go to SEND.
  - SCAN, otherwise: if ptr==WIDTH-1 -> IDLE with snap_done; else ptr++, stay in SCAN.
  - SEND: holds while out_ready=0. On out_ready=1: out_valid=0; if ptr==WIDTH-1 -> IDLE with snap_done; else ptr++ -> SCAN.
- Clear collision: if the capture-and-clear cycle of point i also has a counted hit on i, counter i becomes 1. The captured value excludes that hit.
- Points not yet scanned keep accumulating during a drain. Points already drained restart counting from 0.
- snap_req while snap_busy=1: ignored, with no queuing.
- snap_busy = (state != IDLE).
- Reset values: all counters 0, state IDLE, ptr 0, out_valid 0, out_index 0, out_count 0, snap_done 0, snap_busy 0.
- Reset mid-snapshot: everything above is restored on the next edge. Any beat in flight is dropped. No snap_done is generated.

## Timing
- snap_req sampled at edge n: snap_busy=1 in cycle n+1 (SCAN ptr 0). First out_valid is in cycle n+2.
- Each skipped point costs 1 cycle. Each emitted point costs 2 cycles minimum: the SCAN cycle plus at least one SEND cycle.
- SKIP_ZERO=0 with out_ready tied high gives 2*WIDTH cycles from first SCAN to IDLE.
- SKIP_ZERO=1 with all counters zero: snap_done is high in cycle n+WIDTH+1, and snap_busy is 0 in that same cycle.
- AXI-style handshake: out_index and out_count stay stable while out_valid=1 and out_ready=0. out_valid never drops without acceptance, except on reset.
- A new snap_req is accepted in the snap_done cycle, since the FSM is already in IDLE.

## Structure
- Package cover_pkg holds:
  - the FSM state enum (IDLE, SCAN, SEND);
  - the COVER_IDX_W=32 constant;
  - ptr width as $clog2(WIDTH).
- Sub-module cover_sat_counter (params CNT_W; ports clock, reset, inc, clr, count) is instantiated WIDTH times via generate. It implements the clr+inc->1 rule.
- The top level contains the FSM, the pointer, the read mux over counters, and the output registers.

## Test plan
All scenarios use WIDTH=62, CNT_W=4, COVER_INDEX=100.
- **Saturation:** valid[3] high for 20 cycles with enable=1, then snapshot with SKIP_ZERO=0 -> beat index 103 has count 15. All other beats have count 0. Exactly 62 beats with indices 100..161, in order, then one snap_done pulse.
- **Skip mode:** SKIP_ZERO=1, one hit each on bits 5 and 61 -> exactly two beats, (105,1) then (161,1), then snap_done. A second immediate snapshot yields zero beats and snap_done in cycle req+63.
- **Backpressure:** out_ready low for 5 cycles during the beat for index 105 -> out_valid, out_index and out_count are held constant. After acceptance, the next beat appears.
- **Clear collision:** valid[5] high in the exact capture cycle of point 5 (captured value 3) -> beat count 3. The next snapshot reports (105,1).
- **Enable and ignored request:** enable=0 with all valid bits high for 10 cycles -> all counts 0. A snap_req pulse during SEND -> no second snapshot starts.
- **Reset mid-snapshot:** reset low for one cycle during SEND of index 130 -> out_valid=0, snap_busy=0 and all counters 0 on the next edge, and no snap_done. A following snapshot (SKIP_ZERO=1) yields no beats.

Source files
------------

// File: rtl/cover_pkg.sv
// cover_pkg: shared types and constants for the toggle-coverage collector.
package cover_pkg;

   // Width of the global cover index reported with every beat.
   localparam int COVER_IDX_W = 32;

   // Snapshot drain FSM.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      SEND = 2'd2
   } cover_state_t;

   // Pointer width needed to address every monitored point.
   function automatic int ptr_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/cover_sat_counter.sv
// cover_sat_counter: one saturating hit counter with read-and-clear support.
module cover_sat_counter
   import cover_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] count_r;

   // Saturating count; a hit landing on the clear cycle restarts the count at one.
   always_ff @(posedge clock) begin
      if (!reset) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clr) begin
         count_r <= inc ? CNT_ONE : {CNT_W{1'b0}};
      end else if (inc && (count_r != CNT_MAX)) begin
         count_r <= count_r + CNT_ONE;
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/cover_toggle_collector.sv
// cover_toggle_collector: per-point saturating hit counters drained as a
// (cover index, count) valid/ready stream on request, clearing as they are read.
module cover_toggle_collector
   import cover_pkg::*;
#(
   parameter int          WIDTH       = 62,
   parameter int unsigned COVER_INDEX = 0,
   parameter int          CNT_W       = 8,
   parameter bit          SKIP_ZERO   = 1'b0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       valid,
   input  logic                   enable,
   input  logic                   snap_req,
   output logic                   snap_busy,
   output logic                   snap_done,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [COVER_IDX_W-1:0] out_index,
   output logic [CNT_W-1:0]       out_count
);

   localparam int                     PTR_W    = ptr_width(WIDTH);
   localparam logic [PTR_W-1:0]       LAST_PTR = PTR_W'(WIDTH - 1);
   localparam logic [PTR_W-1:0]       PTR_ONE  = PTR_W'(1);
   localparam logic [COVER_IDX_W-1:0] BASE_IDX = COVER_IDX_W'(COVER_INDEX);

   cover_state_t           state_r;
   logic [PTR_W-1:0]       ptr_r;
   logic                   out_valid_r;
   logic                   snap_done_r;
   logic [COVER_IDX_W-1:0] out_index_r;
   logic [CNT_W-1:0]       out_count_r;

   logic [CNT_W-1:0]       cnt_s [WIDTH];
   logic [WIDTH-1:0]       clr_s;
   logic [CNT_W-1:0]       cur_cnt_s;
   logic                   emit_s;
   logic                   last_s;
   logic [COVER_IDX_W-1:0] idx_s;

   // One counter per monitored point; cleared only in the cycle its value is captured.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pt
         assign clr_s[gi] = (state_r == SCAN) && emit_s && (ptr_r == PTR_W'(gi));
         cover_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock (clock),
            .reset (reset),
            .inc   (enable & valid[gi]),
            .clr   (clr_s[gi]),
            .count (cnt_s[gi])
         );
      end
   endgenerate

   // Read mux over the counters and the emit/last decisions for the scanned point.
   always_comb begin
      cur_cnt_s = {CNT_W{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         if (ptr_r == PTR_W'(i)) begin
            cur_cnt_s = cnt_s[i];
         end else begin
            cur_cnt_s = cur_cnt_s;
         end
      end
      emit_s = !SKIP_ZERO || (cur_cnt_s != {CNT_W{1'b0}});
      last_s = (ptr_r == LAST_PTR);
      idx_s  = BASE_IDX + COVER_IDX_W'(ptr_r);
   end

   // Drain FSM, scan pointer and registered beat outputs.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r     <= IDLE;
         ptr_r       <= {PTR_W{1'b0}};
         out_valid_r <= 1'b0;
         out_index_r <= {COVER_IDX_W{1'b0}};
         out_count_r <= {CNT_W{1'b0}};
         snap_done_r <= 1'b0;
      end else begin
         snap_done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (snap_req) begin
                  state_r <= SCAN;
                  ptr_r   <= {PTR_W{1'b0}};
               end else begin
                  state_r <= IDLE;
               end
            end
            SCAN: begin
               if (emit_s) begin
                  out_valid_r <= 1'b1;
                  out_index_r <= idx_s;
                  out_count_r <= cur_cnt_s;
                  state_r     <= SEND;
               end else if (last_s) begin
                  state_r     <= IDLE;
                  snap_done_r <= 1'b1;
               end else begin
                  ptr_r <= ptr_r + PTR_ONE;
               end
            end
            SEND: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  if (last_s) begin
                     state_r     <= IDLE;
                     snap_done_r <= 1'b1;
                  end else begin
                     state_r <= SCAN;
                     ptr_r   <= ptr_r + PTR_ONE;
                  end
               end else begin
                  state_r <= SEND;
               end
            end
            default: begin
               state_r     <= IDLE;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign snap_busy = (state_r != IDLE);
   assign snap_done = snap_done_r;
   assign out_valid = out_valid_r;
   assign out_index = out_index_r;
   assign out_count = out_count_r;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// tb_cover_toggle_collector: directed checks of the toggle-coverage collector,
// one instance with SKIP_ZERO=0 (dut0) and one with SKIP_ZERO=1 (dut1).
module tb_cover_toggle_collector;

   localparam int WIDTH = 62;
   localparam int CNT_W = 4;
   localparam int CIDX  = 100;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic                  reset;
   logic [WIDTH-1:0]      valid;
   logic                  enable;
   logic [1:0]            snap_req_a;
   logic [1:0]            out_ready_a;
   logic [1:0]            busy_a;
   logic [1:0]            done_a;
   logic [1:0]            ov_a;
   logic [1:0][31:0]      oi_a;
   logic [1:0][CNT_W-1:0] oc_a;

   cover_toggle_collector #(.WIDTH(WIDTH), .COVER_INDEX(CIDX), .CNT_W(CNT_W), .SKIP_ZERO(1'b0)) dut0 (
      .clock(clock), .reset(reset), .valid(valid), .enable(enable),
      .snap_req(snap_req_a[0]), .snap_busy(busy_a[0]), .snap_done(done_a[0]),
      .out_valid(ov_a[0]), .out_ready(out_ready_a[0]), .out_index(oi_a[0]), .out_count(oc_a[0]));

   cover_toggle_collector #(.WIDTH(WIDTH), .COVER_INDEX(CIDX), .CNT_W(CNT_W), .SKIP_ZERO(1'b1)) dut1 (
      .clock(clock), .reset(reset), .valid(valid), .enable(enable),
      .snap_req(snap_req_a[1]), .snap_busy(busy_a[1]), .snap_done(done_a[1]),
      .out_valid(ov_a[1]), .out_ready(out_ready_a[1]), .out_index(oi_a[1]), .out_count(oc_a[1]));

   typedef struct {
      int   bit_i;
      int   hits;
      logic en;
      int   exp_cnt;
   } vec_t;

   vec_t tbl [7];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   bq_idx [$];
   int   bq_cnt [$];
   int   done_k;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset       = 1'b0;
      valid       = '0;
      enable      = 1'b1;
      snap_req_a  = 2'b00;
      out_ready_a = 2'b11;
      step();
      step();
      reset = 1'b1;
   endtask

   // Request a snapshot on instance s with out_ready high, collect beats; at
   // iteration hit_k (cycle req+hit_k) drive a single hit on hit_bit.
   task automatic drain(input int s, input int hit_k, input int hit_bit);
      bq_idx.delete();
      bq_cnt.delete();
      done_k = 0;
      snap_req_a[s] = 1'b1;
      step();
      snap_req_a[s] = 1'b0;
      chk("busy_after_req", longint'(busy_a[s]), 1);
      for (int k = 1; k <= 400; k++) begin
         valid = '0;
         if (k == hit_k) valid[hit_bit] = 1'b1;
         if (ov_a[s]) begin
            bq_idx.push_back(int'(oi_a[s]));
            bq_cnt.push_back(int'(oc_a[s]));
         end
         if (done_a[s]) begin
            done_k = k;
            break;
         end
         step();
      end
      valid = '0;
      chk("drain_done_seen", longint'(done_k != 0), 1);
      chk("busy_low_at_done", longint'(busy_a[s]), 0);
   endtask

   initial begin
      int nb;
      int nz;
      int found;

      tbl[0] = '{3, 20, 1'b1, 15};
      tbl[1] = '{5, 1, 1'b1, 1};
      tbl[2] = '{61, 1, 1'b1, 1};
      tbl[3] = '{0, 15, 1'b1, 15};
      tbl[4] = '{0, 16, 1'b1, 15};
      tbl[5] = '{10, 10, 1'b0, 0};
      tbl[6] = '{7, 14, 1'b1, 14};

      // Reset state of both instances.
      do_reset();
      for (int s = 0; s < 2; s++) begin
         chk("rst_out_valid", longint'(ov_a[s]), 0);
         chk("rst_busy", longint'(busy_a[s]), 0);
         chk("rst_done", longint'(done_a[s]), 0);
         chk("rst_index", longint'(oi_a[s]), 0);
         chk("rst_count", longint'(oc_a[s]), 0);
      end

      // Table: hits on one bit, then a skip-zero snapshot reports at most one beat.
      for (int i = 0; i < 7; i++) begin
         do_reset();
         enable = tbl[i].en;
         for (int h = 0; h < tbl[i].hits; h++) begin
            valid = '0;
            valid[tbl[i].bit_i] = 1'b1;
            step();
         end
         valid  = '0;
         enable = 1'b1;
         drain(1, 0, 0);
         nb = (tbl[i].exp_cnt > 0) ? 1 : 0;
         chk("tbl_nbeats", bq_idx.size(), nb);
         chk("tbl_done_cycle", done_k, 63 + nb);
         if (bq_idx.size() == 1 && nb == 1) begin
            chk("tbl_index", bq_idx[0], CIDX + tbl[i].bit_i);
            chk("tbl_count", bq_cnt[0], tbl[i].exp_cnt);
         end
      end

      // Saturation with full drain on dut0.
      do_reset();
      for (int h = 0; h < 20; h++) begin
         valid = '0;
         valid[3] = 1'b1;
         step();
      end
      valid = '0;
      drain(0, 0, 0);
      chk("sat_nbeats", bq_idx.size(), 62);
      chk("sat_done_cycle", done_k, 125);
      if (bq_idx.size() == 62) begin
         for (int i = 0; i < 62; i++) begin
            chk("sat_index", bq_idx[i], CIDX + i);
            chk("sat_count", bq_cnt[i], (i == 3) ? 15 : 0);
         end
      end
      for (int i = 0; i < 3; i++) begin
         step();
         chk("sat_single_done", longint'(done_a[0]), 0);
      end

      // Skip mode: two beats, then an immediate empty snapshot.
      do_reset();
      valid[5]  = 1'b1;
      valid[61] = 1'b1;
      step();
      valid = '0;
      drain(1, 0, 0);
      chk("skip_nbeats", bq_idx.size(), 2);
      chk("skip_done_cycle", done_k, 65);
      if (bq_idx.size() == 2) begin
         chk("skip_idx0", bq_idx[0], 105);
         chk("skip_cnt0", bq_cnt[0], 1);
         chk("skip_idx1", bq_idx[1], 161);
         chk("skip_cnt1", bq_cnt[1], 1);
      end
      drain(1, 0, 0);
      chk("skip_empty_nbeats", bq_idx.size(), 0);
      chk("skip_empty_done_cycle", done_k, 63);

      // Clear collision: hit on point 5 in its capture cycle.
      do_reset();
      for (int h = 0; h < 3; h++) begin
         valid = '0;
         valid[5] = 1'b1;
         step();
      end
      valid = '0;
      drain(1, 6, 5);
      chk("coll_nbeats", bq_idx.size(), 1);
      if (bq_idx.size() == 1) begin
         chk("coll_index", bq_idx[0], 105);
         chk("coll_count", bq_cnt[0], 3);
      end
      drain(1, 0, 0);
      chk("coll_next_nbeats", bq_idx.size(), 1);
      if (bq_idx.size() == 1) begin
         chk("coll_next_index", bq_idx[0], 105);
         chk("coll_next_count", bq_cnt[0], 1);
      end

      // Enable low: all valid bits high are ignored.
      do_reset();
      enable = 1'b0;
      valid  = '1;
      repeat (10) step();
      valid  = '0;
      enable = 1'b1;
      drain(0, 0, 0);
      chk("en_off_nbeats", bq_idx.size(), 62);
      nz = 0;
      foreach (bq_cnt[i]) if (bq_cnt[i] != 0) nz++;
      chk("en_off_nonzero", nz, 0);

      // Backpressure on index 105 plus a snap_req during SEND that must be ignored.
      do_reset();
      valid[5]  = 1'b1;
      valid[40] = 1'b1;
      step();
      valid = '0;
      out_ready_a[1] = 1'b0;
      snap_req_a[1]  = 1'b1;
      step();
      snap_req_a[1]  = 1'b0;
      for (int k = 0; k < 20 && !ov_a[1]; k++) step();
      chk("bp_first_valid", longint'(ov_a[1]), 1);
      chk("bp_first_index", longint'(oi_a[1]), 105);
      chk("bp_first_count", longint'(oc_a[1]), 1);
      for (int k = 0; k < 5; k++) begin
         if (k == 1) snap_req_a[1] = 1'b1;
         step();
         snap_req_a[1] = 1'b0;
         chk("bp_hold_valid", longint'(ov_a[1]), 1);
         chk("bp_hold_index", longint'(oi_a[1]), 105);
         chk("bp_hold_count", longint'(oc_a[1]), 1);
      end
      out_ready_a[1] = 1'b1;
      step();
      chk("bp_accept_drop", longint'(ov_a[1]), 0);
      for (int k = 0; k < 80 && !ov_a[1]; k++) step();
      chk("bp_next_valid", longint'(ov_a[1]), 1);
      chk("bp_next_index", longint'(oi_a[1]), 140);
      chk("bp_next_count", longint'(oc_a[1]), 1);
      for (int k = 0; k < 80 && !done_a[1]; k++) step();
      chk("bp_done", longint'(done_a[1]), 1);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("ign_req_busy", longint'(busy_a[1]), 0);
         chk("ign_req_valid", longint'(ov_a[1]), 0);
      end

      // Reset during SEND of index 130.
      do_reset();
      valid[30] = 1'b1;
      valid[40] = 1'b1;
      step();
      valid[40] = 1'b0;
      step();
      valid = '0;
      snap_req_a[0] = 1'b1;
      step();
      snap_req_a[0] = 1'b0;
      found = 0;
      for (int k = 0; k < 200; k++) begin
         if (ov_a[0] && oi_a[0] == 32'd130) begin
            found = 1;
            break;
         end
         step();
      end
      chk("rmid_reach_130", found, 1);
      chk("rmid_count_130", longint'(oc_a[0]), 2);
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("rmid_valid", longint'(ov_a[0]), 0);
      chk("rmid_busy", longint'(busy_a[0]), 0);
      chk("rmid_done", longint'(done_a[0]), 0);
      chk("rmid_index", longint'(oi_a[0]), 0);
      chk("rmid_count", longint'(oc_a[0]), 0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("rmid_no_done", longint'(done_a[0]), 0);
         chk("rmid_still_idle", longint'(busy_a[0]), 0);
      end
      drain(1, 0, 0);
      chk("rmid_after_nbeats", bq_idx.size(), 0);
      drain(0, 0, 0);
      nz = 0;
      foreach (bq_cnt[i]) if (bq_cnt[i] != 0) nz++;
      chk("rmid_after_nonzero", nz, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
